// File: rtl/pll_reset_pkg.sv
// pll_reset_pkg
//   Shared definitions for the PLL reset sequencer: sequencer state
//   encoding, reset output bit assignments and the lock-loss counter
//   ceiling.
package pll_reset_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    // Bit positions within rst_out, in release order.
    localparam int unsigned RST_SDRAM = 0;
    localparam int unsigned RST_CPU   = 1;
    localparam int unsigned RST_VIDEO = 2;

    localparam logic [7:0] LOCK_LOST_MAX = 8'd255;

endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer
//   Multi-flop synchronizer for a single asynchronous level signal.
//   Ports:
//     clk_i  destination clock
//     rst_i  asynchronous active-high reset, clears every stage to 0
//     d_i    asynchronous input
//     q_o    synchronized output (last stage of the chain)
module bit_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Turns the raw PLL lock signal into ordered, synchronous reset releases
//   for the SDRAM, CPU and video subsystems. Lock must be stable for
//   LOCK_FILTER cycles before release starts; releases are then spaced by
//   STAGE_DELAY cycles. Lock loss or force_reset re-asserts every reset.
//   Ports:
//     clock            96 MHz system clock (PLL outclk_0)
//     reset            asynchronous active-high reset
//     locked           PLL lock, asynchronous to clock
//     force_reset      synchronous request to restart the sequence
//     rst_out          per-subsystem active-high resets (bit 0 SDRAM,
//                      1 CPU, 2 video), synchronous deassert
//     ready            high once every rst_out bit is low
//     lock_lost_count  saturating count of lock losses seen while running
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_FILTER = 1024,
    parameter int unsigned STAGE_DELAY = 256,
    parameter int unsigned NUM_STAGES  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  locked,
    input  logic                  force_reset,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic [7:0]            lock_lost_count
);

    localparam int unsigned CNT_MAX = (LOCK_FILTER > STAGE_DELAY) ? LOCK_FILTER : STAGE_DELAY;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned IW      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CW-1:0] FILTER_LAST  = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0] DELAY_LAST   = CW'(STAGE_DELAY - 1);
    localparam logic [IW-1:0] LAST_IDX     = IW'(NUM_STAGES - 1);

    logic                  locked_s;

    seq_state_t            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_STAGES-1:0] rst_q, rst_d;
    logic                  ready_q, ready_d;
    logic [7:0]            lost_q, lost_d;
    logic                  abort;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk_i (clock),
        .rst_i (reset),
        .d_i   (locked),
        .q_o   (locked_s)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            lost_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            lost_q  <= lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        lost_d  = lost_q;
        abort   = 1'b0;

        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (locked_s && !force_reset) begin
                    state_d = FILTER;
                end
            end
            FILTER: begin
                if (force_reset || !locked_s) begin
                    abort = 1'b1;
                end else if (cnt_q == FILTER_LAST) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE: begin
                if (force_reset || !locked_s) begin
                    abort = 1'b1;
                end else if (cnt_q == DELAY_LAST) begin
                    // Clearing the last bit leaves rst_out all zero, so RUN
                    // needs no separate output update.
                    rst_d[idx_q] = 1'b0;
                    cnt_d        = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN: begin
                if (force_reset || !locked_s) begin
                    abort = 1'b1;
                    // Only a genuine lock loss counts, even if a force
                    // request coincides with it.
                    if (!locked_s && lost_q != LOCK_LOST_MAX) begin
                        lost_d = lost_q + 8'd1;
                    end
                end
            end
        endcase

        if (abort) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '1;
            ready_d = 1'b0;
        end
    end

    assign rst_out         = rst_q;
    assign ready           = ready_q;
    assign lock_lost_count = lost_q;

endmodule
